// File: rtl/avr_io_pkg.sv
// Shared IO-space constants and debouncer state encoding for the
// AVR-style GPIO blocks: default register addresses and FSM states.
package avr_io_pkg;

    localparam logic [5:0] PIN_ADDR_DEF = 6'h19;
    localparam logic [5:0] MSK_ADDR_DEF = 6'h1A;
    localparam logic [5:0] FLG_ADDR_DEF = 6'h1B;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/pin_debounce.sv
// One-bit 2-flop synchronizer plus tick-sampled debouncer.
// Ports: clk, reset (sync, active-high), pin_i (raw async input),
//        tick_i (shared sample strobe), deb_o (debounced level).
module pin_debounce
    import avr_io_pkg::*;
#(
    parameter int SAMPLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    input  logic tick_i,
    output logic deb_o
);

    localparam logic [3:0] SAMP = 4'(SAMPLES);

    logic       sync1_q;
    logic       sync2_q;
    logic       deb_q;
    logic       deb_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] cnt_inc;
    deb_state_e state_q;
    deb_state_e state_d;

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        if (tick_i) begin
            if (sync2_q == deb_q) begin
                // Input agrees again: any partial count is thrown away.
                state_d = ST_STABLE;
                cnt_d   = 4'd0;
            end else if (cnt_inc == SAMP) begin
                state_d = ST_STABLE;
                cnt_d   = 4'd0;
                deb_d   = sync2_q;
            end else begin
                state_d = ST_PENDING;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= 4'd0;
            state_q <= ST_STABLE;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/gpio_in_port.sv
// Debounced GPIO input port with pin-change mask, W1C flags and irq.
// Ports: clk, reset, pins, io_addr/io_rd/io_wr/io_din, io_dout, irq.
module gpio_in_port
    import avr_io_pkg::*;
#(
    parameter int                       DATA_WIDTH    = 8,
    parameter int                       IO_ADDR_WIDTH = 6,
    parameter logic [IO_ADDR_WIDTH-1:0] PIN_ADDR      = PIN_ADDR_DEF,
    parameter logic [IO_ADDR_WIDTH-1:0] MSK_ADDR      = MSK_ADDR_DEF,
    parameter logic [IO_ADDR_WIDTH-1:0] FLG_ADDR      = FLG_ADDR_DEF,
    parameter logic [15:0]              TICK_DIV      = 16'd50000,
    parameter int                       SAMPLES       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    pins,
    input  logic [IO_ADDR_WIDTH-1:0] io_addr,
    input  logic                     io_rd,
    input  logic                     io_wr,
    input  logic [DATA_WIDTH-1:0]    io_din,
    output logic [DATA_WIDTH-1:0]    io_dout,
    output logic                     irq
);

    logic [15:0]           tick_cnt_q;
    logic [15:0]           tick_cnt_d;
    logic                  tick;
    logic [DATA_WIDTH-1:0] deb;
    logic [DATA_WIDTH-1:0] deb_prev_q;
    logic [DATA_WIDTH-1:0] chg;
    logic [DATA_WIDTH-1:0] msk_q;
    logic [DATA_WIDTH-1:0] msk_d;
    logic [DATA_WIDTH-1:0] flg_q;
    logic [DATA_WIDTH-1:0] flg_d;
    logic [DATA_WIDTH-1:0] clr;
    logic                  irq_q;
    logic                  wr_msk;
    logic                  wr_flg;

    assign tick       = (tick_cnt_q == TICK_DIV - 16'd1);
    assign tick_cnt_d = tick ? 16'd0 : tick_cnt_q + 16'd1;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
        pin_debounce #(
            .SAMPLES(SAMPLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .pin_i (pins[i]),
            .tick_i(tick),
            .deb_o (deb[i])
        );
    end

    assign wr_msk = io_wr && (io_addr == MSK_ADDR);
    assign wr_flg = io_wr && (io_addr == FLG_ADDR);

    // deb and deb_prev_q reset together, so reset never looks like a change.
    assign chg   = deb ^ deb_prev_q;
    assign clr   = wr_flg ? io_din : '0;
    assign msk_d = wr_msk ? io_din : msk_q;
    // Set is OR-ed in after the clear so a same-cycle set wins.
    assign flg_d = (flg_q & ~clr) | (chg & msk_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= 16'd0;
            deb_prev_q <= '0;
            msk_q      <= '0;
            flg_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            deb_prev_q <= deb;
            msk_q      <= msk_d;
            flg_q      <= flg_d;
            irq_q      <= |flg_q;
        end
    end

    assign irq = irq_q;

    always_comb begin
        io_dout = '0;
        if (io_rd) begin
            if (io_addr == PIN_ADDR) begin
                io_dout = deb;
            end else if (io_addr == MSK_ADDR) begin
                io_dout = msk_q;
            end else if (io_addr == FLG_ADDR) begin
                io_dout = flg_q;
            end
        end
    end

endmodule

// File: tb/tb_gpio_in_port.sv
// Directed bench for gpio_in_port with TICK_DIV=4, SAMPLES=3.
// Ticks are consumed at edges where cyc % 4 == 0 after reset release.
module tb_gpio_in_port;

    localparam logic [5:0] A_PIN = 6'h19;
    localparam logic [5:0] A_MSK = 6'h1A;
    localparam logic [5:0] A_FLG = 6'h1B;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pins;
    logic [5:0] io_addr;
    logic       io_rd;
    logic       io_wr;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    gpio_in_port #(
        .TICK_DIV(16'd4),
        .SAMPLES (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pins   (pins),
        .io_addr(io_addr),
        .io_rd  (io_rd),
        .io_wr  (io_wr),
        .io_din (io_din),
        .io_dout(io_dout),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_addr = a;
        io_din  = d;
        io_wr   = 1'b1;
        step();
        io_wr   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a,
                          input logic [7:0] exp);
        io_addr = a;
        io_rd   = 1'b1;
        #1;
        check(tag, io_dout, exp);
        io_rd   = 1'b0;
    endtask

    initial begin
        pins    = 8'h00;
        reset   = 1'b1;
        io_addr = 6'h00;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        io_din  = 8'h00;

        // Reset state
        do_reset();
        rd_chk("rst_pin", A_PIN, 8'h00);
        rd_chk("rst_msk", A_MSK, 8'h00);
        rd_chk("rst_flg", A_FLG, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);

        // Clean edge accepted on third tick (edge 12)
        pins = 8'h01;
        step_to(8);
        rd_chk("acc_t8", A_PIN, 8'h00);
        step_to(11);
        rd_chk("acc_t11", A_PIN, 8'h00);
        step_to(12);
        rd_chk("acc_t12", A_PIN, 8'h01);
        rd_chk("acc_noflg", A_FLG, 8'h00);

        // Glitch seen by the sync output only between ticks
        pins = 8'h00;
        do_reset();
        wr(A_MSK, 8'h01);
        step_to(2);
        pins = 8'h01;
        step_to(5);
        pins = 8'h00;
        step_to(16);
        rd_chk("glitch_pin", A_PIN, 8'h00);
        rd_chk("glitch_flg", A_FLG, 8'h00);
        rd_chk("msk_wr", A_MSK, 8'h01);

        // Mask, flag, irq and W1C
        wr(A_MSK, 8'h81);
        pins = 8'h80;
        step_to(28);
        rd_chk("flg_pre", A_FLG, 8'h00);
        rd_chk("pin7_acc", A_PIN, 8'h80);
        step_to(29);
        rd_chk("flg_set", A_FLG, 8'h80);
        check("irq_lat", {7'd0, irq}, 8'h00);
        step_to(30);
        check("irq_set", {7'd0, irq}, 8'h01);
        rd_chk("flg_rd_keep", A_FLG, 8'h80);
        wr(A_FLG, 8'h80);
        rd_chk("flg_clr", A_FLG, 8'h00);
        check("irq_hold", {7'd0, irq}, 8'h01);
        step();
        check("irq_clr", {7'd0, irq}, 8'h00);

        // Set and clear of flg[0] in the same cycle: set wins
        pins = 8'h81;
        step_to(44);
        wr(A_FLG, 8'h01);
        rd_chk("set_wins", A_FLG, 8'h01);
        wr(A_FLG, 8'h01);
        rd_chk("clr_after", A_FLG, 8'h00);

        // Falling deb edge also flags
        pins = 8'h80;
        step_to(60);
        rd_chk("fall_pin", A_PIN, 8'h80);
        rd_chk("fall_pre", A_FLG, 8'h00);
        step_to(61);
        rd_chk("fall_flg", A_FLG, 8'h01);

        // Reset while bit 2 is pending with cnt=2
        pins = 8'h00;
        do_reset();
        pins = 8'h04;
        step_to(9);
        do_reset();
        rd_chk("rstp_pin", A_PIN, 8'h00);
        rd_chk("rstp_flg", A_FLG, 8'h00);
        step_to(11);
        rd_chk("rstp_t11", A_PIN, 8'h00);
        step_to(12);
        rd_chk("rstp_t12", A_PIN, 8'h04);
        rd_chk("rstp_noflg", A_FLG, 8'h00);

        // Unmapped read, no-strobe read, PIN write ignored
        rd_chk("unmapped", 6'h00, 8'h00);
        io_addr = A_PIN;
        io_rd   = 1'b0;
        #1;
        check("no_rd", io_dout, 8'h00);
        wr(A_PIN, 8'hFF);
        step();
        rd_chk("pin_ro", A_PIN, 8'h04);
        rd_chk("pin_wr_msk", A_MSK, 8'h00);
        rd_chk("pin_wr_flg", A_FLG, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_port.md
GPIO_IN_PORT -- requirements
Module: gpio_in_port

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the port width and the IO data width.
REQ-002 The module SHALL have parameter IO_ADDR_WIDTH, default 6, giving the IO-space address width.
REQ-003 The module SHALL have parameter PIN_ADDR, default 6'h19, the read-only debounced pin register.
REQ-004 The module SHALL have parameter MSK_ADDR, default 6'h1A, the read/write pin-change mask register.
REQ-005 The module SHALL have parameter FLG_ADDR, default 6'h1B, the pin-change flag register (read, write-1-to-clear).
REQ-006 The module SHALL have parameter TICK_DIV, default 16'd50000, giving clock cycles per sample tick (>=2).
REQ-007 The module SHALL have parameter SAMPLES, default 4, giving the consecutive differing ticks needed to accept a level (1..15).
REQ-008 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 The module SHALL have port pins, input, DATA_WIDTH bits: raw asynchronous board inputs (switches/buttons).
REQ-011 The module SHALL have port io_addr, input, IO_ADDR_WIDTH bits: CPU IO address.
REQ-012 The module SHALL have port io_rd, input, 1 bit: IO read strobe.
REQ-013 The module SHALL have port io_wr, input, 1 bit: IO write strobe.
REQ-014 The module SHALL have port io_din, input, DATA_WIDTH bits: CPU write data.
REQ-015 The module SHALL have port io_dout, output, DATA_WIDTH bits: read data.
REQ-016 The module SHALL have port irq, output, 1 bit: pin-change interrupt request.

Function
REQ-017 Each pins bit SHALL pass a 2-flop synchronizer before any other use (sync latency 2 cycles).
REQ-018 A free-running tick counter SHALL assert tick for one cycle every TICK_DIV cycles, first tick TICK_DIV cycles after reset release.
REQ-019 Each bit SHALL run a two-state FSM, STABLE/PENDING, with a 4-bit counter cnt.
REQ-020 On a tick where sync==deb: next state STABLE, cnt:=0.
REQ-021 On a tick where sync!=deb: state PENDING, cnt:=cnt+1; when cnt+1==SAMPLES, deb:=sync, cnt:=0, state STABLE.
REQ-022 Between ticks, the FSM, cnt and deb SHALL hold.
REQ-023 Accept latency SHALL be at most 2+SAMPLES*TICK_DIV+1 cycles from a clean pins edge; a glitch shorter than one tick interval SHALL never change deb.
REQ-024 When deb bit i changes in either direction and msk[i]==1, flg[i] SHALL set on the following cycle.
REQ-025 A write to FLG_ADDR SHALL clear each flg bit whose io_din bit is 1; when a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-026 A write to MSK_ADDR SHALL load msk from io_din the next cycle; a write to PIN_ADDR SHALL be ignored.
REQ-027 irq SHALL equal the OR of flg, registered (1-cycle latency from flg).
REQ-028 io_dout SHALL be combinational: deb, msk or flg when io_rd and io_addr match; 0 otherwise, including unmapped addresses.
REQ-029 Reads SHALL have no side effects.

Reset
REQ-030 While reset is high: sync flops, deb, msk, flg, cnt and tick counter SHALL be 0; all FSMs SHALL be STABLE; irq=0.
REQ-031 Reset mid-PENDING SHALL discard the partial count; no flag SHALL set from the reset-induced deb value.

Structure
REQ-032 Default register addresses and the FSM state encoding SHALL live in a shared package, avr_io_pkg.
REQ-033 The per-bit synchronizer+debouncer SHALL be one sub-module, pin_debounce, instantiated DATA_WIDTH times and sharing the tick.

Verification (TICK_DIV=4, SAMPLES=3)
REQ-034 Raise pins=8'h01 and hold -> PIN reads 8'h01 within 15 cycles; no change before 2 full ticks.
REQ-035 Pulse pins[0] high for 3 cycles between ticks -> PIN stays 8'h00, flg stays 8'h00.
REQ-036 Write MSK=8'h81, toggle pins[7] -> flg=8'h80 and irq=1; write FLG=8'h80 -> flg=8'h00, irq=0 next cycle.
REQ-037 Same cycle flg[0] sets and FLG write 8'h01 -> flg[0] remains 1.
REQ-038 Assert reset while bit 2 is PENDING (cnt=2) -> PIN=8'h00, flg=8'h00; the new level is accepted only after 3 fresh ticks.
REQ-039 Read unmapped address 6'h00 -> io_dout=8'h00; write PIN_ADDR 8'hFF -> PIN unchanged.
